uart_tx_fifo_serial: RTL

//   Downstream stage of the ASCII packet sender. Buffers bytes pushed by the sender
//   in a synchronous FIFO and serialises them onto the UART TX line as 8N1 frames.

---
 rtl/uart_defs_pkg.sv | 14 +
 rtl/tx_byte_fifo.sv | 78 +++++++
 rtl/uart_tx_fifo_serial.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uart_defs_pkg.sv
// rtl/uart_defs_pkg.sv - shared definitions for the UART transmit path
package uart_defs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/tx_byte_fifo.sv
// rtl/tx_byte_fifo.sv - synchronous byte FIFO with registered count and flags
module tx_byte_fifo #(
    parameter int ADDR_W = 4,
    parameter int WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              push_ok;
    logic              pop_ok;

    // Acceptance is judged on the flags as they stood this cycle, so a pop
    // never opens a slot for a simultaneous push into a full FIFO.
    assign push_ok = push && !full_q;
    assign pop_ok  = pop && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/uart_tx_fifo_serial.sv
// rtl/uart_tx_fifo_serial.sv - buffered 8N1 UART transmitter
module uart_tx_fifo_serial
    import uart_defs_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int ADDR_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_push,
    input  logic [7:0] tx_data,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_busy,
    output logic       tx
);

    localparam int BIT_CYC = CLK_FREQ / BAUD;
    localparam int BAUD_W  = $clog2(BIT_CYC);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYC - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              fifo_pop;
    logic [7:0]        fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              baud_done;

    tx_byte_fifo #(
        .ADDR_W (ADDR_W),
        .WIDTH  (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (tx_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign baud_done = (baud_cnt_q == BAUD_LAST);

    // tx_d is the line level for the state being entered, so the registered
    // output changes on the same edge as the state.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_dout;
                    baud_cnt_d = '0;
                    tx_d       = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_d       = shift_q[0];
                    state_d    = ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    tx_d       = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    assign tx       = tx_q;
    assign tx_busy  = (state_q != ST_IDLE);
    assign tx_full  = fifo_full;
    assign tx_empty = fifo_empty;

endmodule
